// File: rtl/c3lib_strap_cfg_ctrl_if.sv
// Strap/override configuration bus.
//   strap_val   : tie-cell default word (static)
//   ovrd_wr     : one-cycle override write strobe
//   ovrd_en     : 1 = apply ovrd_val, 0 = revert to strap_val
//   ovrd_val    : override word
//   cfg_ack     : downstream acceptance of cfg_val
//   cfg_val     : configuration word presented downstream
//   cfg_req     : request to load cfg_val
//   cfg_done    : last word accepted, nothing pending
//   cfg_err     : sticky ack-timeout flag
//   ovrd_active : applied word came from ovrd_val
// master = the environment side, slave = the controller.
interface c3lib_strap_cfg_ctrl_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] strap_val;
  logic             ovrd_wr;
  logic             ovrd_en;
  logic [WIDTH-1:0] ovrd_val;
  logic             cfg_ack;
  logic [WIDTH-1:0] cfg_val;
  logic             cfg_req;
  logic             cfg_done;
  logic             cfg_err;
  logic             ovrd_active;

  modport master (
    output strap_val, ovrd_wr, ovrd_en, ovrd_val, cfg_ack,
    input  cfg_val, cfg_req, cfg_done, cfg_err, ovrd_active
  );

  modport slave (
    input  strap_val, ovrd_wr, ovrd_en, ovrd_val, cfg_ack,
    output cfg_val, cfg_req, cfg_done, cfg_err, ovrd_active
  );
endinterface

// File: rtl/c3lib_strap_cfg_ctrl.sv
// Strap configuration controller.
// After reset the strap inputs are given SETTLE_CYC cycles to settle, then
// captured and offered downstream with a req/ack handshake. Once accepted,
// override writes can replace the word (ovrd_en=1) or revert it to the strap
// (ovrd_en=0). Writes arriving while a handshake is in flight are held in a
// one-deep, last-write-wins pending slot and applied once the block is idle.
// An ack that never comes is abandoned after ACK_TMO cycles and flagged in
// the sticky cfg_err.
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset
//   bus  : strap/override/handshake bundle (slave side)
module c3lib_strap_cfg_ctrl #(
  parameter int WIDTH      = 8,
  parameter int SETTLE_CYC = 4,   // 1..255
  parameter int ACK_TMO    = 64   // 2..65535
) (
  input  logic                  clk,
  input  logic                  rst,
  c3lib_strap_cfg_ctrl_if.slave bus
);

  // Shared by SETTLE and WAIT_ACK; wide enough for the largest ACK_TMO.
  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    ST_SETTLE,
    ST_APPLY,
    ST_WAIT_ACK,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic             en;
    logic [WIDTH-1:0] val;
  } ovrd_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             cnt_inc, cnt_clr;
  logic             ld_strap;   // initial strap capture at end of SETTLE
  logic             ld_pend;    // apply the pending entry
  logic             ld_wr;      // apply the write on the bus this cycle
  logic             err_set;
  logic             req_c, done_c;

  logic             pend_vld;
  ovrd_t            pend;
  ovrd_t            apply_ent;

  logic [WIDTH-1:0] cfg_val_q;
  logic             ovrd_act_q;
  logic             err_q;

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) state <= ST_SETTLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cnt_inc   = 1'b0;
    cnt_clr   = 1'b0;
    ld_strap  = 1'b0;
    ld_pend   = 1'b0;
    ld_wr     = 1'b0;
    err_set   = 1'b0;
    req_c     = 1'b0;
    done_c    = 1'b0;
    case (state)
      ST_SETTLE: begin
        if (cnt == CNT_W'(SETTLE_CYC - 1)) begin
          ld_strap  = 1'b1;
          cnt_clr   = 1'b1;
          state_nxt = ST_APPLY;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      ST_APPLY: begin
        cnt_clr   = 1'b1;
        state_nxt = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        req_c = 1'b1;
        // Ack wins over a timeout landing in the same cycle.
        if (bus.cfg_ack) begin
          cnt_clr   = 1'b1;
          state_nxt = ST_DONE;
        end else if (cnt == CNT_W'(ACK_TMO - 1)) begin
          err_set   = 1'b1;
          cnt_clr   = 1'b1;
          state_nxt = ST_DONE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      ST_DONE: begin
        // A pending entry is older than any write arriving now, so it goes
        // first; the fresh write then falls into the pending slot.
        if (pend_vld) begin
          ld_pend   = 1'b1;
          state_nxt = ST_APPLY;
        end else if (bus.ovrd_wr) begin
          ld_wr     = 1'b1;
          state_nxt = ST_APPLY;
        end else begin
          done_c = 1'b1;
        end
      end
      default: state_nxt = ST_SETTLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || cnt_clr) cnt <= '0;
    else if (cnt_inc)   cnt <= cnt + 1'b1;
  end

  // ---------------------------------------------------------------------
  // Pending override slot
  // ---------------------------------------------------------------------
  // Every write not applied directly lands here, overwriting any older one.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_vld <= 1'b0;
      pend     <= '0;
    end else if (bus.ovrd_wr && !ld_wr) begin
      pend_vld <= 1'b1;
      pend.en  <= bus.ovrd_en;
      pend.val <= bus.ovrd_val;
    end else if (ld_pend) begin
      pend_vld <= 1'b0;
    end
  end

  always_comb begin
    apply_ent     = pend;
    if (!ld_pend) begin
      apply_ent.en  = bus.ovrd_en;
      apply_ent.val = bus.ovrd_val;
    end
  end

  // ---------------------------------------------------------------------
  // Applied word and status
  // ---------------------------------------------------------------------
  // A revert samples strap_val at apply time; between applies cfg_val is
  // held so it stays stable across the handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_val_q  <= '0;
      ovrd_act_q <= 1'b0;
    end else if (ld_strap) begin
      cfg_val_q  <= bus.strap_val;
      ovrd_act_q <= 1'b0;
    end else if (ld_pend || ld_wr) begin
      cfg_val_q  <= apply_ent.en ? apply_ent.val : bus.strap_val;
      ovrd_act_q <= apply_ent.en;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)          err_q <= 1'b0;
    else if (err_set) err_q <= 1'b1;
  end

  // cfg_done drops combinationally in the cycle a write is accepted.
  assign bus.cfg_val     = cfg_val_q;
  assign bus.cfg_req     = req_c & ~rst;
  assign bus.cfg_done    = done_c & ~bus.ovrd_wr & ~rst;
  assign bus.cfg_err     = err_q;
  assign bus.ovrd_active = ovrd_act_q;

endmodule

// File: tb/tb_c3lib_strap_cfg_ctrl.sv
// Self-checking bench for c3lib_strap_cfg_ctrl: directed scenarios followed
// by randomized override/revert traffic checked against a transaction-level
// model (expected word per request, last-write-wins pending collapse).
module tb_c3lib_strap_cfg_ctrl;
  localparam int W   = 8;
  localparam int SC  = 4;
  localparam int TMO = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  c3lib_strap_cfg_ctrl_if #(.WIDTH(W)) bus ();

  c3lib_strap_cfg_ctrl #(.WIDTH(W), .SETTLE_CYC(SC), .ACK_TMO(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [W-1:0] strap;

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic wait_req(input int budget, output int waited);
    waited = 0;
    while (!bus.cfg_req && waited < budget) begin tick(); waited++; end
  endtask

  // Called in the first cycle cfg_req is seen high; acks in its d-th cycle.
  task automatic ack_req(input int d, output int hi);
    hi = 1;
    repeat (d - 1) begin tick(); if (bus.cfg_req) hi++; end
    bus.cfg_ack = 1'b1; tick(); bus.cfg_ack = 1'b0;
  endtask

  task automatic wr(input logic en, input logic [W-1:0] val);
    bus.ovrd_wr = 1'b1; bus.ovrd_en = en; bus.ovrd_val = val;
    tick();
    bus.ovrd_wr = 1'b0;
  endtask

  task automatic idle_quiet(input int n, output logic seen);
    seen = 1'b0;
    repeat (n) begin tick(); if (bus.cfg_req) seen = 1'b1; end
  endtask

  task automatic test_reset;
    strap = 8'hA5; bus.strap_val = strap;
    bus.cfg_ack = 0; bus.ovrd_en = 1; bus.ovrd_val = 8'hFF;
    bus.ovrd_wr = 1'b1;                // must be discarded
    rst = 1'b1;
    tick(3);
    checks++; if (bus.cfg_req !== 1'b0) begin errors++; $display("FAIL rst_req got %b want 0", bus.cfg_req); end
    checks++; if (bus.cfg_done !== 1'b0) begin errors++; $display("FAIL rst_done got %b want 0", bus.cfg_done); end
    checks++; if (bus.cfg_err !== 1'b0) begin errors++; $display("FAIL rst_err got %b want 0", bus.cfg_err); end
    checks++; if (bus.ovrd_active !== 1'b0) begin errors++; $display("FAIL rst_act got %b want 0", bus.ovrd_active); end
    checks++; if (bus.cfg_val !== 8'h00) begin errors++; $display("FAIL rst_val got %h want 00", bus.cfg_val); end
    bus.ovrd_wr = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_powerup;
    int n, hi; logic seen;
    wait_req(20, n);
    checks++; if (!bus.cfg_req || n != SC + 1) begin errors++; $display("FAIL pwr_latency got %0d want %0d", n, SC + 1); end
    checks++; if (bus.cfg_val !== 8'hA5) begin errors++; $display("FAIL pwr_val got %h want a5", bus.cfg_val); end
    ack_req(3, hi);
    checks++; if (hi != 3 || bus.cfg_req !== 1'b0) begin errors++; $display("FAIL pwr_req_len got %0d/%b want 3/0", hi, bus.cfg_req); end
    checks++; if (bus.cfg_done !== 1'b1 || bus.ovrd_active !== 1'b0) begin errors++; $display("FAIL pwr_status got done=%b act=%b want 1/0", bus.cfg_done, bus.ovrd_active); end
    idle_quiet(6, seen);
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL pwr_rst_wr_discard got req=%b want 0", seen); end
  endtask

  task automatic test_override;
    int n, hi;
    bus.ovrd_wr = 1; bus.ovrd_en = 1; bus.ovrd_val = 8'h3C; #1;
    checks++; if (bus.cfg_done !== 1'b0) begin errors++; $display("FAIL ovr_done_on_wr got %b want 0", bus.cfg_done); end
    tick(); bus.ovrd_wr = 0;
    wait_req(4, n);
    checks++; if (!bus.cfg_req || bus.cfg_val !== 8'h3C || bus.ovrd_active !== 1'b1) begin errors++; $display("FAIL ovr_apply got req=%b val=%h act=%b want 1/3c/1", bus.cfg_req, bus.cfg_val, bus.ovrd_active); end
    ack_req(2, hi);
    checks++; if (bus.cfg_done !== 1'b1 || bus.cfg_val !== 8'h3C) begin errors++; $display("FAIL ovr_done got done=%b val=%h want 1/3c", bus.cfg_done, bus.cfg_val); end
    wr(1'b0, 8'h00);
    wait_req(4, n);
    checks++; if (!bus.cfg_req || bus.cfg_val !== 8'hA5 || bus.ovrd_active !== 1'b0) begin errors++; $display("FAIL ovr_revert got req=%b val=%h act=%b want 1/a5/0", bus.cfg_req, bus.cfg_val, bus.ovrd_active); end
    ack_req(1, hi);
  endtask

  task automatic test_strap_change;
    int n, hi;
    strap = 8'h5A; bus.strap_val = strap;
    tick(3);
    checks++; if (bus.cfg_val !== 8'hA5) begin errors++; $display("FAIL strap_hold got %h want a5", bus.cfg_val); end
    wr(1'b0, 8'h00);
    wait_req(4, n);
    checks++; if (!bus.cfg_req || bus.cfg_val !== 8'h5A) begin errors++; $display("FAIL strap_revert got %h want 5a", bus.cfg_val); end
    ack_req(1, hi);
  endtask

  task automatic test_pending;
    int n, hi; logic seen;
    wr(1'b1, 8'h77);
    wait_req(4, n);
    wr(1'b1, 8'h11);
    wr(1'b1, 8'h22);
    bus.cfg_ack = 1; tick(); bus.cfg_ack = 0;
    checks++; if (bus.cfg_req !== 1'b0 || bus.cfg_done !== 1'b0) begin errors++; $display("FAIL pend_hold got req=%b done=%b want 0/0", bus.cfg_req, bus.cfg_done); end
    wait_req(4, n);
    checks++; if (!bus.cfg_req || bus.cfg_val !== 8'h22) begin errors++; $display("FAIL pend_collapse got req=%b val=%h want 1/22", bus.cfg_req, bus.cfg_val); end
    ack_req(1, hi);
    idle_quiet(10, seen);
    checks++; if (seen !== 1'b0 || bus.cfg_done !== 1'b1) begin errors++; $display("FAIL pend_single got extra=%b done=%b want 0/1", seen, bus.cfg_done); end
    // write landing in the same cycle the pending entry is consumed
    wr(1'b1, 8'h44);
    wait_req(4, n);
    wr(1'b1, 8'h55);
    bus.cfg_ack = 1; tick(); bus.cfg_ack = 0;
    wr(1'b1, 8'h66);
    wait_req(4, n);
    checks++; if (!bus.cfg_req || bus.cfg_val !== 8'h55) begin errors++; $display("FAIL pend_consume got val=%h want 55", bus.cfg_val); end
    ack_req(1, hi);
    wait_req(4, n);
    checks++; if (!bus.cfg_req || bus.cfg_val !== 8'h66) begin errors++; $display("FAIL pend_requeue got val=%h want 66", bus.cfg_val); end
    ack_req(1, hi);
  endtask

  task automatic test_timeout;
    int n, hi;
    wr(1'b1, 8'h99);
    wait_req(4, n);
    hi = 1;
    wr(1'b1, 8'hAB);
    if (bus.cfg_req) hi++;
    while (bus.cfg_req && hi < 200) begin tick(); if (bus.cfg_req) hi++; end
    checks++; if (hi != TMO) begin errors++; $display("FAIL tmo_len got %0d want %0d", hi, TMO); end
    checks++; if (bus.cfg_err !== 1'b1) begin errors++; $display("FAIL tmo_err got %b want 1", bus.cfg_err); end
    wait_req(4, n);
    checks++; if (!bus.cfg_req || bus.cfg_val !== 8'hAB) begin errors++; $display("FAIL tmo_pend got req=%b val=%h want 1/ab", bus.cfg_req, bus.cfg_val); end
    ack_req(2, hi);
    checks++; if (bus.cfg_done !== 1'b1 || bus.cfg_err !== 1'b1) begin errors++; $display("FAIL tmo_sticky got done=%b err=%b want 1/1", bus.cfg_done, bus.cfg_err); end
  endtask

  task automatic test_stray_ack_reset;
    int n, hi;
    bus.cfg_ack = 1; tick(3); bus.cfg_ack = 0;
    checks++; if (bus.cfg_req !== 1'b0 || bus.cfg_done !== 1'b1 || bus.cfg_val !== 8'hAB) begin errors++; $display("FAIL stray_ack got req=%b done=%b val=%h want 0/1/ab", bus.cfg_req, bus.cfg_done, bus.cfg_val); end
    wr(1'b1, 8'hC3);
    wait_req(4, n);
    rst = 1; tick();
    checks++; if (bus.cfg_req !== 1'b0 || bus.cfg_err !== 1'b0 || bus.cfg_val !== 8'h00) begin errors++; $display("FAIL mid_rst got req=%b err=%b val=%h want 0/0/00", bus.cfg_req, bus.cfg_err, bus.cfg_val); end
    rst = 0;
    wait_req(20, n);
    checks++; if (!bus.cfg_req || n != SC + 1 || bus.cfg_val !== strap) begin errors++; $display("FAIL rst_restart got n=%0d val=%h want %0d/%h", n, bus.cfg_val, SC + 1, strap); end
    ack_req(1, hi);
  endtask

  task automatic test_random;
    int n, hi, k, extra, d;
    logic en, len;
    logic [W-1:0] val, lval, exp_val;
    for (int it = 0; it < 25; it++) begin
      strap = W'($urandom); bus.strap_val = strap;
      en = 1'($urandom); val = W'($urandom);
      wr(en, val);
      exp_val = en ? val : strap;
      wait_req(4, n);
      checks++; if (!bus.cfg_req || bus.cfg_val !== exp_val || bus.ovrd_active !== en) begin errors++; $display("FAIL rnd_apply it=%0d got req=%b val=%h act=%b want 1/%h/%b", it, bus.cfg_req, bus.cfg_val, bus.ovrd_active, exp_val, en); end
      k = $urandom_range(0, 3);
      len = 1'b0; lval = '0;
      for (int i = 0; i < k; i++) begin
        len = 1'($urandom); lval = W'($urandom);
        wr(len, lval);
      end
      extra = $urandom_range(0, 4);
      tick(extra);
      bus.cfg_ack = 1; tick(); bus.cfg_ack = 0;
      checks++; if (bus.cfg_req !== 1'b0 || bus.cfg_done !== (k == 0)) begin errors++; $display("FAIL rnd_ack it=%0d got req=%b done=%b want 0/%b", it, bus.cfg_req, bus.cfg_done, k == 0); end
      if (k > 0) begin
        exp_val = len ? lval : strap;
        wait_req(4, n);
        checks++; if (!bus.cfg_req || bus.cfg_val !== exp_val || bus.ovrd_active !== len) begin errors++; $display("FAIL rnd_pend it=%0d got req=%b val=%h act=%b want 1/%h/%b", it, bus.cfg_req, bus.cfg_val, bus.ovrd_active, exp_val, len); end
        d = $urandom_range(1, 5);
        ack_req(d, hi);
        checks++; if (hi != d || bus.cfg_done !== 1'b1) begin errors++; $display("FAIL rnd_hs it=%0d got hi=%0d done=%b want %0d/1", it, hi, bus.cfg_done, d); end
      end
    end
  endtask

  initial begin
    bus.strap_val = 8'hA5; bus.ovrd_wr = 0; bus.ovrd_en = 0; bus.ovrd_val = 0; bus.cfg_ack = 0;
    test_reset();
    test_powerup();
    test_override();
    test_strap_change();
    test_pending();
    test_timeout();
    test_stray_ack_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
endmodule

// File: doc/c3lib_strap_cfg_ctrl.md
C3LIB_STRAP_CFG_CTRL -- requirements
Module: c3lib_strap_cfg_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, named clk and rst.
REQ-002 Parameter WIDTH, default 8, SHALL set the configuration word width in bits.
REQ-003 Parameter SETTLE_CYC, default 4, SHALL set the number of cycles the strap inputs settle after reset release; legal range 1..255.
REQ-004 Parameter ACK_TMO, default 64, SHALL set the cfg_ack timeout in cycles; legal range 2..65535.
REQ-005 Port clk, input, 1 bit: the block clock.
REQ-006 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 Port strap_val, input, WIDTH bits: metal-programmable default word from tie-high/tie-low cells; static.
REQ-008 Port ovrd_wr, input, 1 bit: one-cycle write strobe for an override.
REQ-009 Port ovrd_en, input, 1 bit: qualifies ovrd_wr; 1 means apply ovrd_val, 0 means revert to strap_val.
REQ-010 Port ovrd_val, input, WIDTH bits: the override word.
REQ-011 Port cfg_ack, input, 1 bit: downstream acceptance of cfg_val.
REQ-012 Port cfg_val, output, WIDTH bits: the configuration word presented downstream.
REQ-013 Port cfg_req, output, 1 bit: request to load cfg_val.
REQ-014 Port cfg_done, output, 1 bit: high when the last applied word was accepted and nothing is pending.
REQ-015 Port cfg_err, output, 1 bit: sticky flag, set on ack timeout.
REQ-016 Port ovrd_active, output, 1 bit: high when the applied word came from ovrd_val.

Function
REQ-017 The FSM SHALL have the states SETTLE, APPLY, WAIT_ACK and DONE; the encoding is free.
REQ-018 SETTLE SHALL count SETTLE_CYC cycles, then capture strap_val into cfg_val and go to APPLY.
REQ-019 APPLY SHALL assert cfg_req the next cycle and go to WAIT_ACK.
REQ-020 In WAIT_ACK, cfg_req SHALL stay high and cfg_val SHALL stay stable until the cycle cfg_ack=1 is sampled.
REQ-021 On that cfg_ack cycle, cfg_req SHALL deassert on the following cycle and the FSM SHALL go to DONE.
REQ-022 cfg_ack SHALL be ignored while cfg_req=0.
REQ-023 A cycle counter SHALL run in WAIT_ACK.
REQ-024 When the counter reaches ACK_TMO cycles without cfg_ack, the block SHALL set cfg_err, drop cfg_req and go to DONE.
REQ-025 cfg_err SHALL clear only on rst.
REQ-026 In DONE, ovrd_wr=1 with ovrd_en=1 SHALL load ovrd_val into cfg_val, set ovrd_active=1 and go to APPLY.
REQ-027 In DONE, ovrd_wr=1 with ovrd_en=0 SHALL load strap_val into cfg_val, clear ovrd_active and go to APPLY.
REQ-028 An ovrd_wr outside DONE SHALL be captured into a one-deep pending register holding ovrd_en and ovrd_val.
REQ-029 A later ovrd_wr before consumption SHALL overwrite the pending entry (last write wins).
REQ-030 On entering DONE with a pending entry, the block SHALL apply it the next cycle exactly as in REQ-026/REQ-027, then clear the pending flag.
REQ-031 If ovrd_wr arrives in the same cycle the pending entry is consumed, the new write SHALL become the new pending entry.
REQ-032 cfg_done SHALL be 1 only in DONE with no pending entry; it SHALL be 0 in the cycle ovrd_wr is accepted.
REQ-033 A timeout followed by a pending override SHALL still issue the override request.
REQ-034 Changes on strap_val after capture SHALL NOT affect cfg_val until a revert write.

Reset
REQ-035 While rst=1, outputs SHALL be: cfg_req=0, cfg_done=0, cfg_err=0, ovrd_active=0, cfg_val=0.
REQ-036 While rst=1, the pending flag SHALL be 0, the counters SHALL be 0 and the state SHALL be SETTLE.
REQ-037 rst asserted mid-handshake SHALL abandon the request and restart from SETTLE after release.
REQ-038 Any ovrd_wr seen during rst SHALL be discarded.

Verification
REQ-039 Power-up: strap_val=8'hA5, SETTLE_CYC=4, cfg_ack returned 3 cycles after cfg_req -> cfg_val=A5, cfg_req high for exactly 3 cycles, cfg_done=1 and ovrd_active=0 afterwards.
REQ-040 Override and revert in DONE: ovrd_wr with ovrd_en=1, ovrd_val=3C -> cfg_val=3C, ovrd_active=1; then ovrd_wr with ovrd_en=0 -> cfg_val=A5, ovrd_active=0.
REQ-041 Timeout: cfg_ack never asserted, ACK_TMO=64 -> cfg_req drops after 64 cycles in WAIT_ACK, cfg_err=1 sticky, cfg_done=1.
REQ-042 Pending collapse: two ovrd_wr in WAIT_ACK (values 11 then 22) -> after the current ack exactly one further request with cfg_val=22.
REQ-043 Stray ack and reset: cfg_ack pulsed in DONE -> no state change; rst pulsed in WAIT_ACK -> cfg_req=0 next cycle, SETTLE restarts, cfg_err=0.
